// File: rtl/dap_src.sv
// Debug-bus source: two buffered producer channels, round-robin arbitrated onto
// the DB1/DB2/s1/s2 strobe encoding with a programmable idle gap between words.

module dap_src_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [31:0] wdata,
   input  logic        pop,
   output logic [31:0] rdata,
   output logic        full,
   output logic        empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Full/empty come from the current occupancy only; a same-cycle pop frees nothing.
   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == {CW{1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign rdata     = mem[rd_ptr_r];

   // Storage array; entries are only read after being written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem[wr_ptr_r] <= wdata;
      end
   end

   // Read/write pointers (wrap modulo DEPTH) and occupancy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

module dap_src #(
   parameter int DEPTH = 4,
   parameter int GAP   = 2
) (
   input  logic        clk,
   input  logic        MRST,
   input  logic        a_valid,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [31:0] b_data,
   output logic        b_ready,
   input  logic        en,
   output logic [31:0] DB1,
   output logic [31:0] DB2,
   output logic        s1,
   output logic        s2,
   output logic        busy
);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : {GW{1'b0}};
   localparam logic [GW-1:0] GAP_ONE  = GW'(1'b1);
   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EMIT = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t        state_r;
   state_t        next_state_s;
   logic [GW-1:0] gap_r;
   logic [GW-1:0] gap_next_s;
   logic          last_r;
   logic          a_pop_s;
   logic          b_pop_s;
   logic          a_full_s;
   logic          b_full_s;
   logic          a_empty_s;
   logic          b_empty_s;
   logic [31:0]   a_rdata_s;
   logic [31:0]   b_rdata_s;
   logic          pick_a_s;
   logic          pick_b_s;
   logic          launch_s;
   logic          s1_r;
   logic          s2_r;
   logic [31:0]   db1_r;
   logic [31:0]   db2_r;

   dap_src_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .rst   (MRST),
      .push  (a_valid),
      .wdata (a_data),
      .pop   (a_pop_s),
      .rdata (a_rdata_s),
      .full  (a_full_s),
      .empty (a_empty_s)
   );

   dap_src_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .rst   (MRST),
      .push  (b_valid),
      .wdata (b_data),
      .pop   (b_pop_s),
      .rdata (b_rdata_s),
      .full  (b_full_s),
      .empty (b_empty_s)
   );

   // Round-robin: on a tie serve the channel that was not served last.
   assign pick_a_s = ~a_empty_s & (b_empty_s | (last_r == LAST_B));
   assign pick_b_s = ~b_empty_s & ~pick_a_s;
   assign launch_s = en & (pick_a_s | pick_b_s);

   assign a_ready = ~a_full_s;
   assign b_ready = ~b_full_s;
   assign busy    = ~a_empty_s | ~b_empty_s | (state_r != IDLE);
   assign s1      = s1_r;
   assign s2      = s2_r;
   assign DB1     = db1_r;
   assign DB2     = db2_r;

   // FSM state and gap counter registers.
   always_ff @(posedge clk) begin
      if (MRST) begin
         state_r <= IDLE;
         gap_r   <= {GW{1'b0}};
      end else begin
         state_r <= next_state_s;
         gap_r   <= gap_next_s;
      end
   end

   // Next-state, gap counter and FIFO pop decode.
   always_comb begin
      next_state_s = state_r;
      gap_next_s   = gap_r;
      a_pop_s      = 1'b0;
      b_pop_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (launch_s) begin
               next_state_s = EMIT;
               a_pop_s      = pick_a_s;
               b_pop_s      = pick_b_s;
            end else begin
               next_state_s = IDLE;
            end
         end
         EMIT: begin
            if (GAP > 0) begin
               next_state_s = HOLD;
               gap_next_s   = GAP_LOAD;
            end else if (launch_s) begin
               next_state_s = EMIT;
               a_pop_s      = pick_a_s;
               b_pop_s      = pick_b_s;
            end else begin
               next_state_s = IDLE;
            end
         end
         HOLD: begin
            // The IDLE cycle that follows supplies the last idle slot of the gap.
            if (gap_r <= GAP_ONE) begin
               next_state_s = IDLE;
               gap_next_s   = {GW{1'b0}};
            end else begin
               next_state_s = HOLD;
               gap_next_s   = gap_r - GAP_ONE;
            end
         end
         default: begin
            next_state_s = IDLE;
            gap_next_s   = {GW{1'b0}};
         end
      endcase
   end

   // Registered strobes, data buses and last-served flag.
   always_ff @(posedge clk) begin
      if (MRST) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         db1_r  <= 32'h0000_0000;
         db2_r  <= 32'h0000_0000;
         last_r <= LAST_B;
      end else if (a_pop_s) begin
         s1_r   <= 1'b1;
         s2_r   <= 1'b1;
         db1_r  <= a_rdata_s;
         last_r <= LAST_A;
      end else if (b_pop_s) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b1;
         db2_r  <= b_rdata_s;
         last_r <= LAST_B;
      end else begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dap_src.sv
// Self-checking bench for dap_src: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model of the spec rules.
`timescale 1ns/1ps
module tb_dap_src;
   localparam int DEPTH = 4;
   localparam int GAP   = 2;

   logic        clk = 1'b0;
   logic        MRST;
   logic        a_valid, b_valid, en;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, s1, s2, busy;
   logic [31:0] DB1, DB2;

   logic        z_a_valid, z_b_valid, z_en;
   logic [31:0] z_a_data, z_b_data;
   logic        z_a_ready, z_b_ready, z_s1, z_s2, z_busy;
   logic [31:0] z_db1, z_db2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: per-channel word queues and the emission schedule.
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic        m_s1 = 1'b0, m_s2 = 1'b0, m_busy = 1'b0, m_last = 1'b1;
   logic [31:0] m_db1 = 32'h0, m_db2 = 32'h0;
   int          edge_n = 0;
   int          last_emit = -100;

   always #5 clk = ~clk;

   dap_src #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .MRST(MRST),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .en(en), .DB1(DB1), .DB2(DB2), .s1(s1), .s2(s2), .busy(busy)
   );

   dap_src #(.DEPTH(DEPTH), .GAP(0)) dut_b2b (
      .clk(clk), .MRST(MRST),
      .a_valid(z_a_valid), .a_data(z_a_data), .a_ready(z_a_ready),
      .b_valid(z_b_valid), .b_data(z_b_data), .b_ready(z_b_ready),
      .en(z_en), .DB1(z_db1), .DB2(z_db2), .s1(z_s1), .s2(z_s2), .busy(z_busy)
   );

   wire [70:0] obs = {s1, s2, a_ready, b_ready, busy, DB1, DB2};

   function automatic logic [70:0] exp_vec();
      logic ra, rb;
      ra = (qa.size() < DEPTH);
      rb = (qb.size() < DEPTH);
      return {m_s1, m_s2, ra, rb, m_busy, m_db1, m_db2};
   endfunction

   // One clock edge of the spec: a word may go out when en is high, the previous
   // word went out at least GAP+1 edges ago, and something was queued before the edge.
   task automatic model_update();
      logic can, pick_a, pa, pb;
      edge_n++;
      if (MRST) begin
         qa.delete();
         qb.delete();
         m_last = 1'b1;
         m_s1 = 1'b0; m_s2 = 1'b0;
         m_db1 = 32'h0; m_db2 = 32'h0;
         last_emit = edge_n - 100;
      end else begin
         can    = en && (edge_n - last_emit >= GAP + 1) && (qa.size() != 0 || qb.size() != 0);
         pick_a = (qa.size() != 0) && (qb.size() == 0 || m_last);
         pa     = a_valid && (qa.size() < DEPTH);
         pb     = b_valid && (qb.size() < DEPTH);
         if (pa) qa.push_back(a_data);
         if (pb) qb.push_back(b_data);
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         if (can) begin
            last_emit = edge_n;
            if (pick_a) begin
               m_db1 = qa.pop_front(); m_s1 = 1'b1; m_s2 = 1'b1; m_last = 1'b0;
            end else begin
               m_db2 = qb.pop_front(); m_s2 = 1'b1; m_last = 1'b1;
            end
         end
      end
      m_busy = (qa.size() != 0) || (qb.size() != 0) || (edge_n - last_emit < GAP);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      MRST = 1'b1;
      for (int c = 0; c < 2; c++) begin
         a_valid = 1'($urandom_range(0, 1)); a_data = $urandom();
         b_valid = 1'($urandom_range(0, 1)); b_data = $urandom();
         en = 1'($urandom_range(0, 1));
         tick();
      end
      n_checks++;
      if ({s1, s2} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes got=%b want=00", {s1, s2}); end
      n_checks++;
      if ({DB1, DB2} !== 64'h0) begin n_errors++; $display("FAIL reset_data got=%h want=0", {DB1, DB2}); end
      n_checks++;
      if ({a_ready, b_ready, busy} !== 3'b110) begin n_errors++; $display("FAIL reset_flags got=%b want=110", {a_ready, b_ready, busy}); end
      n_checks++;
      if ({z_s1, z_s2, z_a_ready, z_b_ready, z_busy, z_db1, z_db2} !== {5'b00110, 64'h0}) begin
         n_errors++; $display("FAIL reset_b2b got=%b want=00110", {z_s1, z_s2, z_a_ready, z_b_ready, z_busy});
      end
      n_checks++;
      if (obs !== exp_vec()) begin n_errors++; $display("FAIL reset_model got=%h want=%h", obs, exp_vec()); end
      MRST = 1'b0; a_valid = 1'b0; b_valid = 1'b0; en = 1'b0;
   endtask

   task automatic test_single_a();
      en = 1'b1; a_valid = 1'b1; a_data = 32'hDEADBEEF;
      for (int c = 0; c < 4; c++) begin
         tick();
         a_valid = 1'b0;
         n_checks++;
         if ({s1, s2} !== ((c == 1) ? 2'b11 : 2'b00)) begin
            n_errors++; $display("FAIL single_a_strobe cyc=%0d got=%b want=%b", c, {s1, s2}, (c == 1) ? 2'b11 : 2'b00);
         end
         if (c >= 1) begin
            n_checks++;
            if (DB1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_a_db1 cyc=%0d got=%h want=deadbeef", c, DB1); end
         end
         n_checks++;
         if (obs !== exp_vec()) begin n_errors++; $display("FAIL single_a_model cyc=%0d got=%h want=%h", c, obs, exp_vec()); end
      end
   endtask

   task automatic test_single_b();
      en = 1'b1; b_valid = 1'b1; b_data = 32'h12345678;
      for (int c = 0; c < 4; c++) begin
         tick();
         b_valid = 1'b0;
         n_checks++;
         if ({s1, s2} !== ((c == 1) ? 2'b01 : 2'b00)) begin
            n_errors++; $display("FAIL single_b_strobe cyc=%0d got=%b want=%b", c, {s1, s2}, (c == 1) ? 2'b01 : 2'b00);
         end
         if (c >= 1) begin
            n_checks++;
            if ({DB1, DB2} !== {32'hDEADBEEF, 32'h12345678}) begin
               n_errors++; $display("FAIL single_b_data cyc=%0d got=%h want=deadbeef12345678", c, {DB1, DB2});
            end
         end
         n_checks++;
         if (obs !== exp_vec()) begin n_errors++; $display("FAIL single_b_model cyc=%0d got=%h want=%h", c, obs, exp_vec()); end
      end
   endtask

   task automatic test_round_robin();
      logic [32:0] seen[$];
      int          at[$];
      logic [32:0] want [4];
      want[0] = {1'b1, 32'd1}; want[1] = {1'b0, 32'd10};
      want[2] = {1'b1, 32'd2}; want[3] = {1'b0, 32'd20};
      en = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 32'd1; b_data = 32'd10;
      tick();
      a_data = 32'd2; b_data = 32'd20;
      tick();
      a_valid = 1'b0; b_valid = 1'b0; en = 1'b1;
      for (int c = 0; c < 14; c++) begin
         tick();
         n_checks++;
         if (obs !== exp_vec()) begin n_errors++; $display("FAIL rr_model cyc=%0d got=%h want=%h", c, obs, exp_vec()); end
         if (s2) begin
            seen.push_back({s1, s1 ? DB1 : DB2});
            at.push_back(c);
         end
      end
      n_checks++;
      if (seen.size() != 4) begin
         n_errors++; $display("FAIL rr_count got=%0d want=4", seen.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (seen[i] !== want[i]) begin n_errors++; $display("FAIL rr_order idx=%0d got=%h want=%h", i, seen[i], want[i]); end
            n_checks++;
            if (at[i] != 3 * i) begin n_errors++; $display("FAIL rr_spacing idx=%0d got=%0d want=%0d", i, at[i], 3 * i); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [4];
      z_en = 1'b0; z_a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom();
         z_a_data = w[i];
         tick();
      end
      z_a_valid = 1'b0;
      n_checks++;
      if (z_a_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_full got=%b want=0", z_a_ready); end
      z_en = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         n_checks++;
         if ({z_s1, z_s2} !== ((c <= 4) ? 2'b11 : 2'b00)) begin
            n_errors++; $display("FAIL b2b_strobe cyc=%0d got=%b want=%b", c, {z_s1, z_s2}, (c <= 4) ? 2'b11 : 2'b00);
         end
         n_checks++;
         if (z_db1 !== w[(c <= 4) ? c - 1 : 3]) begin
            n_errors++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", c, z_db1, w[(c <= 4) ? c - 1 : 3]);
         end
         if (c == 1) begin
            n_checks++;
            if (z_a_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready got=%b want=1", z_a_ready); end
         end
      end
      z_en = 1'b0;
   endtask

   task automatic test_full_wrap();
      logic [31:0] w [8];
      logic [31:0] seen[$];
      for (int i = 0; i < 8; i++) w[i] = $urandom();
      en = 1'b0; a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_data = w[i];
         tick();
      end
      n_checks++;
      if (a_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready got=%b want=0", a_ready); end
      a_data = 32'hBAD0_0005;
      tick();
      n_checks++;
      if ({a_ready, busy} !== 2'b01) begin n_errors++; $display("FAIL full_fifth got=%b want=01", {a_ready, busy}); end
      a_valid = 1'b0; en = 1'b1;
      for (int c = 0; c < 34; c++) begin
         if (c >= 16 && c < 20) begin a_valid = 1'b1; a_data = w[c - 12]; end
         else a_valid = 1'b0;
         tick();
         n_checks++;
         if (obs !== exp_vec()) begin n_errors++; $display("FAIL wrap_model cyc=%0d got=%h want=%h", c, obs, exp_vec()); end
         if (s1 && s2) seen.push_back(DB1);
      end
      a_valid = 1'b0;
      n_checks++;
      if (seen.size() != 8) begin
         n_errors++; $display("FAIL wrap_count got=%0d want=8", seen.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen[i] !== w[i]) begin n_errors++; $display("FAIL wrap_order idx=%0d got=%h want=%h", i, seen[i], w[i]); end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic        found;
      logic [32:0] seen[$];
      en = 1'b0; a_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_data = 32'hA000_0000 + i;
         tick();
      end
      a_valid = 1'b0; en = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         if (s1 && s2) found = 1'b1;
      end
      n_checks++;
      if (!found) begin n_errors++; $display("FAIL midrst_emit got=none want=strobe"); end
      tick();
      n_checks++;
      if ({s1, s2, busy} !== 3'b001) begin n_errors++; $display("FAIL midrst_hold got=%b want=001", {s1, s2, busy}); end
      MRST = 1'b1;
      tick();
      MRST = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if ({s1, s2, a_ready, b_ready, busy, DB1, DB2} !== {5'b00110, 64'h0}) begin
            n_errors++; $display("FAIL midrst_quiet cyc=%0d got=%h want=%h", c, obs, {5'b00110, 64'h0});
         end
      end
      a_valid = 1'b1; a_data = 32'h5555_AAAA; b_valid = 1'b1; b_data = 32'h0F0F_0F0F;
      for (int c = 0; c < 8; c++) begin
         tick();
         a_valid = 1'b0; b_valid = 1'b0;
         n_checks++;
         if (obs !== exp_vec()) begin n_errors++; $display("FAIL midrst_model cyc=%0d got=%h want=%h", c, obs, exp_vec()); end
         if (s2) seen.push_back({s1, s1 ? DB1 : DB2});
      end
      n_checks++;
      if (seen.size() != 2) begin
         n_errors++; $display("FAIL midrst_count got=%0d want=2", seen.size());
      end else begin
         n_checks++;
         if ({seen[0], seen[1]} !== {1'b1, 32'h5555_AAAA, 1'b0, 32'h0F0F_0F0F}) begin
            n_errors++; $display("FAIL midrst_order got=%h want=%h", {seen[0], seen[1]}, {1'b1, 32'h5555_AAAA, 1'b0, 32'h0F0F_0F0F});
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 440; c++) begin
         if (c < 400) begin
            a_valid = 1'($urandom_range(0, 1)); a_data = $urandom();
            b_valid = 1'($urandom_range(0, 1)); b_data = $urandom();
            en = ($urandom_range(0, 3) != 0);
         end else begin
            a_valid = 1'b0; b_valid = 1'b0; en = 1'b1;
         end
         tick();
         n_checks++;
         if (obs !== exp_vec()) begin n_errors++; $display("FAIL random_model cyc=%0d got=%h want=%h", c, obs, exp_vec()); end
      end
   endtask

   initial begin
      MRST = 1'b1; en = 1'b0;
      a_valid = 1'b0; a_data = 32'h0; b_valid = 1'b0; b_data = 32'h0;
      z_a_valid = 1'b0; z_a_data = 32'h0; z_b_valid = 1'b0; z_b_data = 32'h0; z_en = 1'b0;
      test_reset();
      test_single_a();
      test_single_b();
      test_round_robin();
      test_back_to_back();
      test_full_wrap();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
